// File: rtl/rx_lane_sync_ctrl_if.sv
// Lane bundle between the deserializer byte stream and the sync controller.
// master: the controller (consumes data_in, drives status and forwarded data).
// slave:  the deserializer/downstream side (drives data_in, observes the rest).
interface rx_lane_sync_ctrl_if;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic       slip;
    logic [2:0] slip_amt;
    logic [3:0] err_cnt;

    modport master (
        input  data_in,
        output data_out,
        output valid_out,
        output active,
        output slip,
        output slip_amt,
        output err_cnt
    );

    modport slave (
        output data_in,
        input  data_out,
        input  valid_out,
        input  active,
        input  slip,
        input  slip_amt,
        input  err_cnt
    );
endinterface

// File: rtl/rx_lane_sync_ctrl.sv
// Per-lane receive synchronisation controller on the deserializer byte clock.
// Finds comma alignment (commanding bit slips on rotated commas), declares
// lock after a run of aligned commas, then forwards data bytes and strips
// idle commas, dropping lock after a run of rotated-comma errors.
//
// state     | meaning
// ----------+----------------------------------------------------------
// SEARCH    | unaligned, hunting for a comma or a rotated comma
// SLIP_HOLD | slip issued, ignoring bytes while the deserializer settles
// LOCKING   | counting consecutive aligned commas toward lock
// LOCKED    | lane active, forwarding data and counting rotation errors
module rx_lane_sync_ctrl #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 4,
    parameter int         SLIP_WAIT  = 3
) (
    input  logic                       clk_4f,
    input  logic                       reset_L,
    rx_lane_sync_ctrl_if.master        lane
);

    localparam logic [3:0] LOCK_CNT_L = 4'(LOCK_COUNT);
    localparam logic [3:0] LOSS_CNT_L = 4'(LOSS_COUNT);
    localparam logic [2:0] WAIT_L     = 3'(SLIP_WAIT);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKING   = 2'd2,
        LOCKED    = 2'd3
    } state_t;

    state_t     state;
    logic [3:0] comma_cnt;
    logic [2:0] wait_cnt;

    logic       is_comma;
    logic       is_rot;
    logic [2:0] rot_fix;

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Classify the incoming byte; rot_fix is the left rotation (8-k) that realigns ROT(k).
    always_comb begin
        is_comma = (lane.data_in == COMMA);
        is_rot   = 1'b0;
        rot_fix  = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (!is_comma && lane.data_in == rotl8(COMMA, k)) begin
                is_rot  = 1'b1;
                rot_fix = 3'(8 - k);
            end
        end
    end

    // Alignment FSM with registered outputs; slip is a single-cycle pulse.
    always_ff @(posedge clk_4f or negedge reset_L) begin
        if (!reset_L) begin
            state          <= SEARCH;
            comma_cnt      <= 4'd0;
            wait_cnt       <= 3'd0;
            lane.data_out  <= 8'd0;
            lane.valid_out <= 1'b0;
            lane.active    <= 1'b0;
            lane.slip      <= 1'b0;
            lane.slip_amt  <= 3'd0;
            lane.err_cnt   <= 4'd0;
        end else begin
            lane.slip <= 1'b0;
            case (state)
                SEARCH: begin
                    lane.valid_out <= 1'b0;
                    lane.active    <= 1'b0;
                    if (is_comma) begin
                        if (LOCK_CNT_L <= 4'd1) begin
                            comma_cnt   <= LOCK_CNT_L;
                            lane.active <= 1'b1;
                            state       <= LOCKED;
                        end else begin
                            comma_cnt <= 4'd1;
                            state     <= LOCKING;
                        end
                    end else if (is_rot) begin
                        lane.slip     <= 1'b1;
                        lane.slip_amt <= rot_fix;
                        wait_cnt      <= WAIT_L;
                        state         <= SLIP_HOLD;
                    end
                end

                // The byte on which the count reaches zero is the last one ignored.
                SLIP_HOLD: begin
                    lane.valid_out <= 1'b0;
                    if (wait_cnt < 3'd2) begin
                        wait_cnt <= 3'd0;
                        state    <= SEARCH;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end

                LOCKING: begin
                    lane.valid_out <= 1'b0;
                    if (is_comma) begin
                        if (comma_cnt + 4'd1 >= LOCK_CNT_L) begin
                            comma_cnt   <= LOCK_CNT_L;
                            lane.active <= 1'b1;
                            state       <= LOCKED;
                        end else begin
                            comma_cnt <= comma_cnt + 4'd1;
                        end
                    end else if (is_rot) begin
                        lane.slip     <= 1'b1;
                        lane.slip_amt <= rot_fix;
                        wait_cnt      <= WAIT_L;
                        comma_cnt     <= 4'd0;
                        state         <= SLIP_HOLD;
                    end else begin
                        comma_cnt <= 4'd0;
                        state     <= SEARCH;
                    end
                end

                // Loss of lock does not slip; the next rotation seen in SEARCH does.
                LOCKED: begin
                    if (is_comma) begin
                        lane.valid_out <= 1'b0;
                        lane.err_cnt   <= 4'd0;
                    end else if (is_rot) begin
                        lane.valid_out <= 1'b0;
                        if (lane.err_cnt + 4'd1 >= LOSS_CNT_L) begin
                            lane.err_cnt <= 4'd0;
                            lane.active  <= 1'b0;
                            comma_cnt    <= 4'd0;
                            state        <= SEARCH;
                        end else begin
                            lane.err_cnt <= lane.err_cnt + 4'd1;
                        end
                    end else begin
                        lane.data_out  <= lane.data_in;
                        lane.valid_out <= 1'b1;
                    end
                end

                default: begin
                    state <= SEARCH;
                end
            endcase
        end
    end

endmodule

// File: doc/rx_lane_sync_ctrl.md
Name: rx_lane_sync_ctrl

Overview:
Per-lane receive synchronisation controller. It sits directly after the serial-to-parallel deserializer and runs on its byte clock.
- Watches the recovered byte stream for the comma symbol and its bit-rotated images.
- Commands bit slips to the deserializer and declares lane lock after a run of aligned commas.
- Once locked, forwards data bytes with valid, strips idle commas, and drops lock on sustained misalignment.

Parameters:
COMMA, 8'hBC, comma/idle symbol
LOCK_COUNT, 4, consecutive aligned commas needed to declare lock (1..15)
LOSS_COUNT, 4, consecutive rotated-comma errors while locked that force loss of lock (1..15)
SLIP_WAIT, 3, byte cycles ignored after a slip pulse while the deserializer realigns (1..7)

Ports:
clk_4f  input  1  byte clock; all logic on rising edge
reset_L  input  1  asynchronous active-low reset
data_in  input  8  byte from deserializer, new byte every clk_4f
data_out  output  8  forwarded data byte
valid_out  output  1  data_out holds a valid data byte this cycle
active  output  1  lane locked
slip  output  1  one-cycle pulse: deserializer must rotate its bit boundary
slip_amt  output  3  left-rotation count k to apply, valid with slip
err_cnt  output  4  current consecutive-error count (debug)

Behaviour:
- Reset (reset_L=0, asynchronous):
  - data_out=0, valid_out=0, active=0, slip=0, slip_amt=0, err_cnt=0.
  - Internal comma counter=0, wait counter=0, state=SEARCH.
  - Reset has priority over everything. Asserting it mid-stream aborts any state immediately.
- Symbol classes, decoded combinationally from data_in:
  - COMMA: exact match with COMMA.
  - ROT(k): data_in equals COMMA rotated left by k, k=1..7. For 8'hBC: 79,F2,E5,CB,97,2F,5E give k=1..7.
  - DATA: anything else.
  - slip_amt = 8-k, the left rotation that restores alignment.
- State SEARCH:
  - COMMA -> comma counter=1, go LOCKING. If LOCK_COUNT=1, go straight to LOCKED.
  - ROT(k) -> slip=1 and slip_amt=8-k for exactly one cycle; wait counter=SLIP_WAIT; go SLIP_HOLD.
  - DATA -> stay.
  - Outputs: valid_out=0, active=0.
- State SLIP_HOLD:
  - Decrement the wait counter each cycle and ignore data_in.
  - When the counter reaches 0, return to SEARCH on the next cycle.
  - slip stays 0 in this state. A second slip is impossible before SLIP_WAIT+1 cycles have passed.
- State LOCKING:
  - COMMA -> increment the counter. When the counter reaches LOCK_COUNT, go LOCKED.
  - ROT(k) -> issue a slip as in SEARCH, clear the counter, go SLIP_HOLD.
  - DATA -> clear the counter, go SEARCH.
  - valid_out=0.
- State LOCKED:
  - active=1, registered on the transition cycle.
  - DATA -> data_out<=data_in, valid_out<=1. Latency is exactly one clk_4f from sample to output.
  - COMMA -> valid_out<=0 (idle stripped), data_out holds its previous value, err_cnt<=0.
  - ROT(k) -> valid_out<=0, err_cnt<=err_cnt+1, no slip.
  - If err_cnt+1 reaches LOSS_COUNT: go SEARCH, active<=0, err_cnt<=0, valid_out<=0. The slip for this rotation is not issued; the next ROT seen in SEARCH triggers it.
  - DATA does not change err_cnt. Only a COMMA clears it.
- Counters saturate and never wrap. The comma counter stops at LOCK_COUNT; err_cnt cannot exceed LOSS_COUNT.
- The first byte after entering LOCKED is processed by the LOCKED rules in that cycle's successor. The lock-completing comma itself is never forwarded.

Test Plan:
- Reset mid-LOCKED while valid_out=1 -> all outputs 0 asynchronously; after release, state SEARCH and bytes 8'h55 produce valid_out=0.
- Stream BC,BC,BC,BC then 8'h12,8'h34 -> active=1 on the cycle after the 4th BC; valid_out=1 with data_out=12 then 34, each one cycle after input.
- Locked stream 12,BC,BC,34 -> outputs: valid 12, valid_out=0 for two cycles, valid 34; data_out holds 12 during the idles.
- Stream 8'h79 in SEARCH -> single-cycle slip=1 with slip_amt=7; 8'h79 on the next 3 cycles produces no slip; a slip is possible again on the 5th cycle.
- Locked, then 97,97,BC,97,97,97,97 -> err_cnt goes 1,2,0,1,2,3, then active=0 after the 4th consecutive 97; no slip pulse on that cycle.
- In LOCKING after BC,BC, byte 8'h00 -> back to SEARCH; lock then requires 4 fresh BCs (check active=0 after only 3).
